// File: rtl/seq_shift_engine.sv
// Command-driven multi-cycle shifter: accepts op+amount over valid/ready, applies
// one bit-step per clock, pulses done on completion; abort cancels a running shift.
module seq_shift_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int SHAMT_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [SHAMT_W-1:0]    cmd_amt,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ser_in,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  shout,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] OP_CLEAR = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_LSR   = 3'b010;
    localparam logic [2:0] OP_LSL   = 3'b011;
    localparam logic [2:0] OP_ASR   = 3'b100;
    localparam logic [2:0] OP_SIR   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_ROL   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state;
    logic [2:0]              op_r;
    logic [SHAMT_W-1:0]      cnt;
    logic [DATA_WIDTH:0]     step_nxt;

    // Returns {bit shifted out, new word} for one step of a shift op.
    function automatic logic [DATA_WIDTH:0] shift_step(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] v,
        input logic                  s
    );
        logic signed [DATA_WIDTH-1:0] vs;
        logic [DATA_WIDTH-1:0]        r;
        logic                         o;
        vs = v;
        r  = v;
        o  = v[0];
        case (op)
            OP_LSR: r = v >> 1;
            OP_LSL: begin
                r = v << 1;
                o = v[DATA_WIDTH-1];
            end
            OP_ASR: r = vs >>> 1;
            OP_SIR: r = {s, v[DATA_WIDTH-1:1]};
            OP_ROR: r = {v[0], v[DATA_WIDTH-1:1]};
            OP_ROL: begin
                r = {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
                o = v[DATA_WIDTH-1];
            end
            default: ;
        endcase
        return {o, r};
    endfunction

    assign step_nxt = shift_step(op_r, q, ser_in);
    assign busy     = !cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_r      <= OP_CLEAR;
            cnt       <= '0;
            q         <= '0;
            shout     <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_r      <= cmd_op;
                        cmd_ready <= 1'b0;
                        if (cmd_op == OP_CLEAR) begin
                            q     <= '0;
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (cmd_op == OP_LOAD) begin
                            q     <= data_in;
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (cmd_amt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt   <= cmd_amt;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Abort wins over the step due at this edge; partial result is kept.
                    if (abort) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        cmd_ready <= 1'b1;
                    end else begin
                        q     <= step_nxt[DATA_WIDTH-1:0];
                        shout <= step_nxt[DATA_WIDTH];
                        cnt   <= cnt - 1'b1;
                        if (cnt == SHAMT_W'(1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
